// File: rtl/gmii_frame_tx.sv
`timescale 1ns/1ps
// GMII/MII frame transmitter: preamble, SFD, body, optional zero pad and CRC32 FCS, then idle gap.
// PHY outputs are registered; in_ready depends on state/phase only and an empty input in DATA aborts the frame.
module gmii_frame_tx #(
    parameter int DATA_W         = 8,
    parameter int PREAMBLE_BYTES = 7,
    parameter int IFG_BYTES      = 12,
    parameter bit PAD_EN         = 1'b1,
    parameter bit FCS_EN         = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              gmii_txctrl,
    output logic [DATA_W-1:0] gmii_txdata,
    output logic              gmii_txerr,
    output logic              busy,
    output logic              underrun,
    output logic [15:0]       frame_cnt
);
    localparam bit          MII      = (DATA_W == 4);
    localparam int          IFG_CLKS = IFG_BYTES * 8 / DATA_W;
    localparam logic [9:0]  PRE_LAST = 10'(PREAMBLE_BYTES - 1);
    localparam logic [9:0]  IFG_LAST = 10'(IFG_CLKS - 1);
    localparam logic [10:0] MIN_BODY = 11'd60;

    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, DROP, PAD, FCS, IFG} state_t;

    state_t      state_q, state_d;
    logic        phase_q, phase_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [10:0] body_q, body_d, body_inc;
    logic [31:0] crc_q, crc_d, fcs_word;
    logic [7:0]  hold_q, hold_d;
    logic        hold_last_q, hold_last_d;
    logic [7:0]  beat, beat_sel;
    logic        ctrl_d, err_d, urun_d;
    logic [15:0] fcnt_d;
    logic        ph_next, byte_end, fin, post, ifg_ok;

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? 32'hEDB8_8320 : 32'h0);
        return r;
    endfunction

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        phase_d     = 1'b0;
        cnt_d       = cnt_q;
        body_d      = body_q;
        crc_d       = crc_q;
        hold_d      = hold_q;
        hold_last_d = hold_last_q;
        beat        = 8'h00;
        ctrl_d      = 1'b0;
        err_d       = 1'b0;
        urun_d      = 1'b0;
        fcnt_d      = frame_cnt;
        in_ready    = 1'b0;
        fin         = 1'b0;
        post        = 1'b0;
        ifg_ok      = 1'b0;
        ph_next     = MII ? ~phase_q : 1'b0;
        byte_end    = !MII || phase_q;
        body_inc    = (body_q == 11'h7FF) ? body_q : body_q + 11'd1;
        fcs_word    = ~crc_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ctrl_d  = 1'b1;
                    beat    = 8'h55;
                    phase_d = ph_next;
                    body_d  = '0;
                    cnt_d   = '0;
                    if (!byte_end)
                        state_d = PREAMBLE;
                    else if (PREAMBLE_BYTES == 1)
                        state_d = SFD;
                    else begin
                        state_d = PREAMBLE;
                        cnt_d   = 10'd1;
                    end
                end
            end
            PREAMBLE: begin
                ctrl_d  = 1'b1;
                beat    = 8'h55;
                phase_d = ph_next;
                if (byte_end) begin
                    if (cnt_q == PRE_LAST) begin
                        state_d = SFD;
                        cnt_d   = '0;
                    end else
                        cnt_d = cnt_q + 10'd1;
                end
            end
            SFD: begin
                ctrl_d  = 1'b1;
                beat    = 8'hD5;
                phase_d = ph_next;
                if (byte_end)
                    state_d = DATA;
            end
            DATA: begin
                ctrl_d = 1'b1;
                if (!phase_q) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        beat        = in_data;
                        phase_d     = ph_next;
                        crc_d       = crc_upd(crc_q, in_data);
                        body_d      = body_inc;
                        hold_d      = in_data;
                        hold_last_d = in_last;
                        fin         = byte_end && in_last;
                    end else begin
                        // Source ran dry mid-frame: poison the frame on the wire and discard the rest.
                        err_d   = 1'b1;
                        urun_d  = 1'b1;
                        state_d = DROP;
                    end
                end else begin
                    beat = hold_q;
                    fin  = hold_last_q;
                end
            end
            DROP: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_d = IFG;
                    cnt_d   = '0;
                    crc_d   = '1;
                end
            end
            PAD: begin
                ctrl_d  = 1'b1;
                phase_d = ph_next;
                if (!phase_q) begin
                    crc_d  = crc_upd(crc_q, 8'h00);
                    body_d = body_inc;
                end
                post = byte_end && (body_d >= MIN_BODY);
            end
            FCS: begin
                ctrl_d  = 1'b1;
                beat    = fcs_word[{cnt_q[1:0], 3'b000} +: 8];
                phase_d = ph_next;
                if (byte_end) begin
                    if (cnt_q[1:0] == 2'd3)
                        ifg_ok = 1'b1;
                    else
                        cnt_d = cnt_q + 10'd1;
                end
            end
            IFG: begin
                if (cnt_q == IFG_LAST)
                    state_d = IDLE;
                else
                    cnt_d = cnt_q + 10'd1;
            end
            default: state_d = IDLE;
        endcase

        if (fin) begin
            if (PAD_EN && (body_d < MIN_BODY))
                state_d = PAD;
            else
                post = 1'b1;
        end
        if (post) begin
            if (FCS_EN) begin
                state_d = FCS;
                cnt_d   = '0;
            end else
                ifg_ok = 1'b1;
        end
        if (ifg_ok) begin
            state_d = IFG;
            cnt_d   = '0;
            crc_d   = '1;
            fcnt_d  = frame_cnt + 16'd1;
        end

        // MII sends the low nibble of each byte first.
        beat_sel = MII ? {4'h0, (phase_q ? beat[7:4] : beat[3:0])} : beat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= 1'b0;
            cnt_q       <= '0;
            body_q      <= '0;
            crc_q       <= '1;
            hold_q      <= '0;
            hold_last_q <= 1'b0;
            gmii_txctrl <= 1'b0;
            gmii_txdata <= '0;
            gmii_txerr  <= 1'b0;
            underrun    <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            body_q      <= body_d;
            crc_q       <= crc_d;
            hold_q      <= hold_d;
            hold_last_q <= hold_last_d;
            gmii_txctrl <= ctrl_d;
            gmii_txdata <= beat_sel[DATA_W-1:0];
            gmii_txerr  <= err_d;
            underrun    <= urun_d;
            frame_cnt   <= fcnt_d;
        end
    end
endmodule
